// File: rtl/crc16_pkg.sv
// Shared CRC-16 constants and checker state encoding.
// Used by the serial checker, its LFSR step and the reference models.
package crc16_pkg;
    localparam int                CRC_W    = 16;
    localparam logic [CRC_W-1:0] POLY_DEF = 16'h1021;
    localparam logic [CRC_W-1:0] INIT_DEF = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/crc16_lfsr_step.sv
// One-bit CRC-16 LFSR update, MSB first, non-reflected.
// Purely combinational; no latency, no flow control.
module crc16_lfsr_step
    import crc16_pkg::*;
(
    input  logic [CRC_W-1:0] lfsr_cur,
    input  logic             din,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] lfsr_nxt
);
    logic fb;

    assign fb       = lfsr_cur[CRC_W-1] ^ din;
    assign lfsr_nxt = {lfsr_cur[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
endmodule

// File: rtl/crc16_serial_checker.sv
// Serial CRC-16 frame checker: strips 16 trailing CRC bits, emits data bytes, reports verdict.
// byte_valid/done one cycle after the accepted bit; one bit per clock, no backpressure.
module crc16_serial_checker
    import crc16_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY  = POLY_DEF,
    parameter logic [CRC_W-1:0] INIT  = INIT_DEF,
    parameter int               LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             d_finish,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [LEN_W-1:0] frame_len
);
    state_t           state, state_nxt;
    logic             accept, finish;
    logic [CRC_W-1:0] lfsr, lfsr_nxt;
    logic [CRC_W-1:0] dline;
    logic [7:0]       asm_sh, asm_new;
    // tot saturates at 24: enough to know "delay line full" (>=16) and "long enough" (>=24)
    logic [4:0]       tot, tot_inc;
    logic [2:0]       mod8, mod8_inc;
    logic             push, byte_done, len_max, ovf, ovf_nxt, pass;

    crc16_lfsr_step u_step (
        .lfsr_cur (lfsr),
        .din      (bit_in),
        .poly     (POLY),
        .lfsr_nxt (lfsr_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (load)        state_nxt = RECV;
        else if (finish) state_nxt = DONE;
    end

    always_comb begin
        accept = (state == RECV) && bit_valid && !load;
        finish = accept && d_finish;
    end

    // Pushed-bit phase equals total-bit phase because the delay line holds a multiple of 8 bits.
    assign tot_inc   = (tot == 5'd24) ? tot : tot + 5'd1;
    assign mod8_inc  = mod8 + 3'd1;
    assign push      = (tot >= 5'd16);
    assign asm_new   = {asm_sh[6:0], dline[CRC_W-1]};
    assign byte_done = accept && push && (mod8 == 3'd7);
    assign len_max   = (frame_len == '1);
    assign ovf_nxt   = ovf | (byte_done & len_max);
    assign pass      = (lfsr_nxt == '0) && (tot_inc >= 5'd24) && (mod8_inc == 3'd0) && !ovf_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= INIT;
            dline      <= '0;
            asm_sh     <= '0;
            tot        <= '0;
            mod8       <= '0;
            ovf        <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            done       <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
            frame_len  <= '0;
        end else begin
            byte_valid <= 1'b0;
            done       <= 1'b0;
            if (load) begin
                lfsr      <= INIT;
                dline     <= '0;
                asm_sh    <= '0;
                tot       <= '0;
                mod8      <= '0;
                ovf       <= 1'b0;
                byte_out  <= '0;
                crc_ok    <= 1'b0;
                crc_err   <= 1'b0;
                frame_len <= '0;
            end else if (accept) begin
                lfsr  <= lfsr_nxt;
                dline <= {dline[CRC_W-2:0], bit_in};
                tot   <= tot_inc;
                mod8  <= mod8_inc;
                ovf   <= ovf_nxt;
                if (push) asm_sh <= asm_new;
                if (byte_done) begin
                    byte_out   <= asm_new;
                    byte_valid <= 1'b1;
                    if (!len_max) frame_len <= frame_len + 1'b1;
                end
                if (d_finish) begin
                    done    <= 1'b1;
                    crc_ok  <= pass;
                    crc_err <= !pass;
                end
            end
        end
    end
endmodule
